// File: rtl/lfsr_4bit_pkg.sv
// Shared types and defaults for the seeded LFSR burst generator.
package lfsr_4bit_pkg;

  typedef enum logic [1:0] {
    ST_GEN    = 2'd0,
    ST_SERIAL = 2'd1,
    ST_DONE   = 2'd2
  } lfsr_state_e;

  // x^4 + x^3 + 1: maximal length, period 15
  localparam logic [3:0] DEFAULT_TAPS = 4'b1100;

endpackage

// File: rtl/lfsr_4bit_core.sv
// Fibonacci LFSR register: seeded load, feedback shift, and zero-fill right shift for draining.
module lfsr_4bit_core #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             gen_en,
  input  logic             ser_en,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] r_d, r_q;
  logic             fb;

  always_comb begin
    fb  = ^(r_q & TAPS);
    r_d = r_q;
    if (load)
      // An all-zero register would never leave zero, so substitute 1.
      r_d = (seed == '0) ? WIDTH'(1) : seed;
    else if (gen_en)
      r_d = {r_q[WIDTH-2:0], fb};
    else if (ser_en)
      r_d = r_q >> 1;
  end

  always_ff @(posedge clk) r_q <= r_d;

  assign r = r_q;

endmodule

// File: rtl/lfsr_4bit.sv
// Runs the LFSR GEN_CYCLES times after reset, then emits the register LSB-first with a valid strobe.
module lfsr_4bit
  import lfsr_4bit_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = DEFAULT_TAPS,
  parameter int               GEN_CYCLES = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] seed,
  output logic             OUT,
  output logic             Valid
);

  localparam int               CNT_MAX  = (GEN_CYCLES > WIDTH) ? GEN_CYCLES : WIDTH;
  localparam int               CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]    GEN_LAST = CW'(GEN_CYCLES - 1);
  localparam logic [CW-1:0]    SER_LAST = CW'(WIDTH - 1);

  lfsr_state_e      state_d, state_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             out_d, out_q;
  logic             valid_d, valid_q;
  logic [WIDTH-1:0] r;

  lfsr_4bit_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .clk    (CLK),
    .load   (RST),
    .seed   (seed),
    .gen_en (state_q == ST_GEN),
    .ser_en (state_q == ST_SERIAL),
    .r      (r)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    if (RST) begin
      state_d = ST_GEN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_GEN: begin
          if (cnt_q == GEN_LAST) begin
            cnt_d   = '0;
            state_d = ST_SERIAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SERIAL: begin
          out_d   = r[0];
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == SER_LAST) state_d = ST_DONE;
        end
        ST_DONE: ;
        default: state_d = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    out_q   <= out_d;
    valid_q <= valid_d;
  end

  assign OUT   = out_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_lfsr_4bit.sv
// Directed checks of the LFSR burst: reset load, GEN trajectory, serial burst, zero seed, mid-run reset, DONE hold.
module tb_lfsr_4bit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] seed = 4'b0000;
  logic       OUT, Valid;
  int         total = 0;
  int         bad   = 0;

  lfsr_4bit dut (.CLK(CLK), .RST(RST), .seed(seed), .OUT(OUT), .Valid(Valid));

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; seed = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (OUT !== 1'b0) begin bad++; $display("FAIL reset_out cyc=%0d got=%b want=0", i, OUT); end
      total++; if (Valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc=%0d got=%b want=0", i, Valid); end
      total++; if (dut.r !== 4'b1001) begin bad++; $display("FAIL reset_r cyc=%0d got=%b want=1001", i, dut.r); end
    end
  endtask

  task automatic test_seed_1001();
    logic [3:0] r_exp [8] = '{4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111};
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (dut.r !== r_exp[i]) begin bad++; $display("FAIL gen1001_r edge=%0d got=%b want=%b", i+1, dut.r, r_exp[i]); end
      total++; if (Valid !== 1'b0 || OUT !== 1'b0) begin bad++; $display("FAIL gen1001_out edge=%0d got=%b%b want=00", i+1, Valid, OUT); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (Valid !== 1'b1 || OUT !== 1'b1) begin bad++; $display("FAIL ser1001 edge=%0d valid/out got=%b%b want=11", i+9, Valid, OUT); end
    end
    step();
    total++; if (Valid !== 1'b0 || OUT !== 1'b0) begin bad++; $display("FAIL end1001 edge=13 valid/out got=%b%b want=00", Valid, OUT); end
  endtask

  // Eight shifts from 0001 pass through 0010,0100,1001,0011,0110,1101,1010 and end at 0101.
  task automatic test_seed_0001();
    logic [3:0] bits = 4'b0101;
    RST = 1'b1; seed = 4'b0001;
    step();
    RST = 1'b0; seed = 4'b1110;
    for (int i = 0; i < 8; i++) step();
    total++; if (dut.r !== 4'b0101) begin bad++; $display("FAIL gen0001_r got=%b want=0101", dut.r); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (Valid !== 1'b1 || OUT !== bits[i]) begin bad++; $display("FAIL ser0001 bit=%0d valid/out got=%b%b want=1%b", i, Valid, OUT, bits[i]); end
    end
    step();
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL end0001 valid got=%b want=0", Valid); end
  endtask

  task automatic test_zero_seed();
    logic [3:0] bits = 4'b0101;
    RST = 1'b1; seed = 4'b0000;
    step();
    total++; if (dut.r !== 4'b0001) begin bad++; $display("FAIL zero_load got=%b want=0001", dut.r); end
    RST = 1'b0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (Valid !== 1'b1 || OUT !== bits[i]) begin bad++; $display("FAIL zero_ser bit=%0d valid/out got=%b%b want=1%b", i, Valid, OUT, bits[i]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] bits = 4'b0101;
    RST = 1'b1; seed = 4'b1001;
    step();
    RST = 1'b0;
    for (int i = 0; i < 9; i++) step();
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL mid_pre valid got=%b want=1", Valid); end
    RST = 1'b1; seed = 4'b0001;
    step();
    total++; if (Valid !== 1'b0 || OUT !== 1'b0) begin bad++; $display("FAIL mid_rst valid/out got=%b%b want=00", Valid, OUT); end
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (Valid !== 1'b0) begin bad++; $display("FAIL mid_gen edge=%0d valid got=%b want=0", i+1, Valid); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (Valid !== 1'b1 || OUT !== bits[i]) begin bad++; $display("FAIL mid_ser bit=%0d valid/out got=%b%b want=1%b", i, Valid, OUT, bits[i]); end
    end
  endtask

  task automatic test_done_hold();
    int errs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (Valid !== 1'b0 || OUT !== 1'b0 || dut.r !== 4'b0000) begin
        bad++; errs++;
        if (errs < 4) $display("FAIL done_hold cyc=%0d valid/out/r got=%b%b%b want=000000", i, Valid, OUT, dut.r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seed_1001();
    test_seed_0001();
    test_zero_seed();
    test_mid_reset();
    test_done_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
